// File: rtl/joy_serial_scanner.sv
// joy_serial_scanner
// Scans a chain of 74HC165-style shift registers carrying joystick buttons.
// Each scan loads the chain, clocks out PLAYERS*BITS bits (twice when
// PHASES=2, with joy_sel low for the second pass), then publishes the
// decoded, active-high state only when two consecutive scans agree.
module joy_serial_scanner #(
    parameter int CLK_DIV   = 8,
    parameter int PLAYERS   = 2,
    parameter int BITS      = 8,
    parameter int PHASES    = 1,
    parameter int GAP_TICKS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             joy_data,
    output logic                             joy_clk,
    output logic                             joy_load_n,
    output logic                             joy_sel,
    output logic [PLAYERS*PHASES*BITS-1:0]   joy_out,
    output logic                             joy_valid
);

    localparam int W     = PHASES * BITS;
    localparam int TOT   = PLAYERS * W;
    localparam int CNT_W = (CLK_DIV > 1)   ? $clog2(CLK_DIV)   : 1;
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int BIT_W = (BITS > 1)      ? $clog2(BITS)      : 1;
    localparam int PL_W  = (PLAYERS > 1)   ? $clog2(PLAYERS)   : 1;
    localparam int POS_W = (TOT > 1)       ? $clog2(TOT)       : 1;

    typedef enum logic [2:0] {
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_NEXT,
        S_GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic             tick;
    logic [GAP_W-1:0] gap_cnt;
    logic [BIT_W-1:0] bit_idx;
    logic [PL_W-1:0]  player_idx;
    logic             phase;
    logic             last_bit;
    logic             data_p0;
    logic             data_p1;
    logic [POS_W-1:0] pos;
    logic [TOT-1:0]   raw;
    logic [TOT-1:0]   prev;

    assign tick     = (int'(div_cnt) == CLK_DIV - 1);
    assign last_bit = (int'(bit_idx) == BITS - 1) && (int'(player_idx) == PLAYERS - 1);

    // Stream bit k lands MSB-first inside its player's field for the current phase.
    assign pos = POS_W'(int'(player_idx) * W + int'(phase) * BITS + (BITS - 1) - int'(bit_idx));

    // Tick divider: one tick every CLK_DIV cycles, restarting from 0 after reset.
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk) begin
        data_p0 <= joy_data;
        data_p1 <= data_p0;
    end

    // Capture one inverted bit per rising shift clock into the raw scan image.
    always_ff @(posedge clk) begin
        if (tick && state == S_SHIFT_LO) begin
            raw[pos] <= ~data_p1;
        end
    end

    // Scan sequencer: drives the chain pins and publishes debounced results.
    always_ff @(posedge clk) begin
        joy_valid <= 1'b0;
        if (reset) begin
            state      <= S_LOAD;
            joy_clk    <= 1'b0;
            joy_load_n <= 1'b1;
            joy_sel    <= 1'b1;
            joy_out    <= '0;
            prev       <= '1;
            phase      <= 1'b0;
            gap_cnt    <= '0;
            bit_idx    <= '0;
            player_idx <= '0;
        end else if (tick) begin
            case (state)
                S_LOAD: begin
                    joy_load_n <= 1'b0;
                    joy_clk    <= 1'b0;
                    bit_idx    <= '0;
                    player_idx <= '0;
                    state      <= S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    joy_load_n <= 1'b1;
                    joy_clk    <= 1'b1;
                    state      <= S_SHIFT_HI;
                end
                S_SHIFT_HI: begin
                    joy_clk <= 1'b0;
                    if (last_bit) begin
                        state <= S_NEXT;
                    end else begin
                        if (int'(bit_idx) == BITS - 1) begin
                            bit_idx    <= '0;
                            player_idx <= player_idx + 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                        state <= S_SHIFT_LO;
                    end
                end
                S_NEXT: begin
                    if (PHASES == 2 && !phase) begin
                        // Select line settles a full tick before the second load.
                        joy_sel <= 1'b0;
                        phase   <= 1'b1;
                        state   <= S_LOAD;
                    end else begin
                        if (raw == prev) begin
                            joy_out   <= raw;
                            joy_valid <= 1'b1;
                        end
                        prev    <= raw;
                        joy_sel <= 1'b1;
                        phase   <= 1'b0;
                        gap_cnt <= '0;
                        state   <= (GAP_TICKS == 0) ? S_LOAD : S_GAP;
                    end
                end
                S_GAP: begin
                    if (int'(gap_cnt) == GAP_TICKS - 1) begin
                        state <= S_LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule
